// File: rtl/gsensor_pkg.sv
// Shared types and constants for the accelerometer sequencer and its command ROM.
package gsensor_pkg;

    typedef enum logic [2:0] {
        OP_START     = 3'd0,
        OP_RESTART   = 3'd1,
        OP_WRITE     = 3'd2,
        OP_READ_ACK  = 3'd3,
        OP_READ_NACK = 3'd4,
        OP_STOP      = 3'd5
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_CFG,
        ST_WAIT,
        ST_READ,
        ST_ERR
    } state_e;

    localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
    localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
    localparam logic [7:0] REG_DATAX0      = 8'h32;

    localparam logic [7:0] VAL_DATA_FORMAT = 8'h0B;
    localparam logic [7:0] VAL_POWER_CTL   = 8'h08;

    localparam int         STEP_W          = 5;
    localparam logic [4:0] STEP_CFG_FIRST  = 5'd0;
    localparam logic [4:0] STEP_READ_FIRST = 5'd10;

    function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rd);
        return {addr, rd};
    endfunction

endpackage

// File: rtl/gsensor_cmd_rom.sv
// Fixed command ROM: CFG occupies steps 0-9, the X/Y/Z burst read steps 10-21.
module gsensor_cmd_rom
    import gsensor_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h1D
) (
    input  logic [STEP_W-1:0] step,
    output cmd_op_e           op,
    output logic [7:0]        data,
    output logic              last,
    output logic              is_rd
);

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        op    = OP_STOP;
        data  = 8'h00;
        last  = 1'b0;
        is_rd = 1'b0;
        case (step)
            5'd0:  op = OP_START;
            5'd1:  begin op = OP_WRITE; data = addr_byte(DEV_ADDR, 1'b0); end
            5'd2:  begin op = OP_WRITE; data = REG_DATA_FORMAT; end
            5'd3:  begin op = OP_WRITE; data = VAL_DATA_FORMAT; end
            5'd4:  op = OP_STOP;
            5'd5:  op = OP_START;
            5'd6:  begin op = OP_WRITE; data = addr_byte(DEV_ADDR, 1'b0); end
            5'd7:  begin op = OP_WRITE; data = REG_POWER_CTL; end
            5'd8:  begin op = OP_WRITE; data = VAL_POWER_CTL; end
            5'd9:  begin op = OP_STOP; last = 1'b1; end
            5'd10: op = OP_START;
            5'd11: begin op = OP_WRITE; data = addr_byte(DEV_ADDR, 1'b0); end
            5'd12: begin op = OP_WRITE; data = REG_DATAX0; end
            5'd13: op = OP_RESTART;
            5'd14: begin op = OP_WRITE; data = addr_byte(DEV_ADDR, 1'b1); end
            5'd15, 5'd16, 5'd17, 5'd18, 5'd19:
                   begin op = OP_READ_ACK; is_rd = 1'b1; end
            5'd20: begin op = OP_READ_NACK; is_rd = 1'b1; end
            5'd21: begin op = OP_STOP; last = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/gsensor_ctrl.sv
// Accelerometer sequencer: configures the sensor, then polls X/Y/Z through a
// byte-level I2C engine, one command outstanding at a time, with NACK recovery.
module gsensor_ctrl
    import gsensor_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR       = 7'h1D,
    parameter int unsigned POLL_CYCLES    = 50000,
    parameter int unsigned STARTUP_CYCLES = 1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_op,
    output logic [7:0]  cmd_data,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_data,
    input  logic        rsp_nack,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic        sample_valid,
    output logic        error,
    output logic        busy
);

    localparam int PW = (POLL_CYCLES > 0) ? $clog2(POLL_CYCLES + 1) : 1;
    localparam int SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam logic [PW-1:0] POLL_TC  = PW'(POLL_CYCLES);
    localparam logic [SW-1:0] START_TC = (STARTUP_CYCLES > 0) ? SW'(STARTUP_CYCLES - 1) : '0;

    state_e            state_q, state_n;
    logic [STEP_W-1:0] step_q, step_n;
    logic [2:0]        cap_q, cap_n;
    logic [SW-1:0]     st_cnt_q, st_cnt_n;
    logic [PW-1:0]     poll_q, poll_n;
    logic              issue_q, issue_n;
    logic              cfg_retry_q, cfg_retry_n;

    cmd_op_e     cmd_op_q;
    cmd_op_e     rom_op;
    logic [7:0]  rom_data;
    logic        rom_last;
    logic        rom_is_rd;
    cmd_op_e     issue_op;
    logic [7:0]  issue_data;
    logic        outstanding;
    logic        rsp_ok;
    logic        nack_evt;
    logic        done_evt;
    logic        capture;
    logic        sample_evt;
    logic [7:0]  byte_buf [0:5];

    gsensor_cmd_rom #(.DEV_ADDR(DEV_ADDR)) u_rom (
        .step  (step_q),
        .op    (rom_op),
        .data  (rom_data),
        .last  (rom_last),
        .is_rd (rom_is_rd)
    );

    // Responses only count against a command the engine has actually accepted.
    assign rsp_ok   = rsp_valid && outstanding;
    assign nack_evt = rsp_ok && rsp_nack && (cmd_op_q == OP_WRITE)
                      && ((state_q == ST_CFG) || (state_q == ST_READ));
    assign done_evt = rsp_ok && !nack_evt;

    assign issue_op   = (state_q == ST_ERR) ? OP_STOP : rom_op;
    assign issue_data = (state_q == ST_ERR) ? 8'h00 : rom_data;

    assign busy   = (state_q == ST_CFG) || (state_q == ST_READ) || (state_q == ST_ERR);
    assign cmd_op = cmd_op_q;

    always_comb begin
        state_n     = state_q;
        step_n      = step_q;
        cap_n       = cap_q;
        st_cnt_n    = st_cnt_q;
        poll_n      = poll_q;
        cfg_retry_n = cfg_retry_q;
        issue_n     = 1'b0;
        capture     = 1'b0;
        sample_evt  = 1'b0;
        case (state_q)
            ST_STARTUP: begin
                if (st_cnt_q == START_TC) begin
                    state_n = ST_CFG;
                    step_n  = STEP_CFG_FIRST;
                    issue_n = 1'b1;
                end else begin
                    st_cnt_n = st_cnt_q + SW'(1);
                end
            end
            ST_CFG: begin
                if (nack_evt) begin
                    state_n     = ST_ERR;
                    cfg_retry_n = 1'b1;
                    issue_n     = 1'b1;
                end else if (done_evt) begin
                    if (rom_last) begin
                        state_n     = ST_WAIT;
                        poll_n      = '0;
                        cfg_retry_n = 1'b0;
                    end else begin
                        step_n  = step_q + STEP_W'(1);
                        issue_n = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // A failed configuration is retried without waiting for enable.
                if (poll_q != POLL_TC) begin
                    poll_n = poll_q + PW'(1);
                end else if (cfg_retry_q) begin
                    state_n = ST_CFG;
                    step_n  = STEP_CFG_FIRST;
                    issue_n = 1'b1;
                end else if (enable) begin
                    state_n = ST_READ;
                    step_n  = STEP_READ_FIRST;
                    cap_n   = '0;
                    issue_n = 1'b1;
                end
            end
            ST_READ: begin
                if (nack_evt) begin
                    state_n = ST_ERR;
                    issue_n = 1'b1;
                end else if (done_evt) begin
                    if (rom_is_rd) begin
                        capture = 1'b1;
                        cap_n   = cap_q + 3'd1;
                    end
                    if (rom_last) begin
                        sample_evt = 1'b1;
                        state_n    = ST_WAIT;
                        poll_n     = '0;
                    end else begin
                        step_n  = step_q + STEP_W'(1);
                        issue_n = 1'b1;
                    end
                end
            end
            ST_ERR: begin
                if (rsp_ok) begin
                    state_n = ST_WAIT;
                    poll_n  = '0;
                end
            end
            default: state_n = ST_STARTUP;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_STARTUP;
            step_q      <= '0;
            cap_q       <= '0;
            st_cnt_q    <= '0;
            poll_q      <= '0;
            issue_q     <= 1'b0;
            cfg_retry_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            step_q      <= step_n;
            cap_q       <= cap_n;
            st_cnt_q    <= st_cnt_n;
            poll_q      <= poll_n;
            issue_q     <= issue_n;
            cfg_retry_q <= cfg_retry_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd_valid    <= 1'b0;
            cmd_op_q     <= OP_START;
            cmd_data     <= 8'h00;
            outstanding  <= 1'b0;
            accel_x      <= 16'h0000;
            accel_y      <= 16'h0000;
            accel_z      <= 16'h0000;
            sample_valid <= 1'b0;
            error        <= 1'b0;
        end else begin
            sample_valid <= sample_evt;
            if (issue_q) begin
                cmd_valid <= 1'b1;
                cmd_op_q  <= issue_op;
                cmd_data  <= issue_data;
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid   <= 1'b0;
                outstanding <= 1'b1;
            end
            if (rsp_ok) begin
                outstanding <= 1'b0;
            end
            if (nack_evt) begin
                error <= 1'b1;
            end else if (sample_evt) begin
                error <= 1'b0;
            end
            if (sample_evt) begin
                accel_x <= {byte_buf[1], byte_buf[0]};
                accel_y <= {byte_buf[3], byte_buf[2]};
                accel_z <= {byte_buf[5], byte_buf[4]};
            end
        end
    end

    // NOTE: the byte buffer has no reset; it is only read after all six bytes of a read are captured.
    always_ff @(posedge CLK) begin
        if (capture) begin
            byte_buf[cap_q] <= rsp_data;
        end
    end

endmodule

// File: tb/tb_gsensor_ctrl.sv
// Directed bench for gsensor_ctrl: the bench plays the I2C byte engine and checks
// the command stream, sample results, NACK recovery, enable gating and reset.
module tb_gsensor_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        enable = 1'b1;
    logic        cmd_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic        rsp_nack = 1'b0;
    logic [7:0]  rsp_data = 8'h00;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic [15:0] accel_x, accel_y, accel_z;
    logic        sample_valid, error, busy;

    int checks = 0;
    int failures = 0;
    int sv_cnt = 0;
    bit hs_bad = 1'b0;
    logic [7:0] rd_bytes [6];

    // Expected {op[2:0], data[7:0]} per command.
    logic [10:0] cfg_exp [10] = '{11'h000, 11'h23A, 11'h231, 11'h20B, 11'h500,
                                  11'h000, 11'h23A, 11'h22D, 11'h208, 11'h500};
    logic [10:0] rd_exp  [12] = '{11'h000, 11'h23A, 11'h232, 11'h100, 11'h23B,
                                  11'h300, 11'h300, 11'h300, 11'h300, 11'h300,
                                  11'h400, 11'h500};

    gsensor_ctrl #(
        .DEV_ADDR       (7'h1D),
        .POLL_CYCLES    (20),
        .STARTUP_CYCLES (1000)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .enable       (enable),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_nack     (rsp_nack),
        .accel_x      (accel_x),
        .accel_y      (accel_y),
        .accel_z      (accel_z),
        .sample_valid (sample_valid),
        .error        (error),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (sample_valid === 1'b1) sv_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Engine model: wait for a command, hold off bp cycles, accept, respond 4 cycles later.
    task automatic serve_one(input int bp, input logic nack, input logic [7:0] rdat,
                             output logic [10:0] got);
        int t = 0;
        got = 11'h7FF;
        while (cmd_valid !== 1'b1 && t < 3000) begin
            @(negedge CLK);
            t++;
        end
        if (cmd_valid !== 1'b1) begin
            check("cmd_wait", {63'd0, cmd_valid}, 64'd1);
            return;
        end
        got = {cmd_op, cmd_data};
        for (int i = 0; i < bp; i++) begin
            @(negedge CLK);
            if (cmd_valid !== 1'b1 || {cmd_op, cmd_data} !== got) hs_bad = 1'b1;
        end
        cmd_ready = 1'b1;
        @(negedge CLK);
        cmd_ready = 1'b0;
        if (cmd_valid !== 1'b0) hs_bad = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            if (cmd_valid !== 1'b0) hs_bad = 1'b1;
        end
        rsp_valid = 1'b1;
        rsp_nack  = nack;
        rsp_data  = rdat;
        @(negedge CLK);
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
        rsp_data  = 8'h00;
    endtask

    task automatic expect_cmd(input string tag, input int bp, input logic nack,
                              input logic [7:0] rdat, input logic [10:0] exp);
        logic [10:0] got;
        serve_one(bp, nack, rdat, got);
        check(tag, {53'd0, got}, {53'd0, exp});
    endtask

    task automatic run_read(input string tag, input int bp, input int ncmd);
        logic [7:0] rdat;
        for (int i = 0; i < ncmd; i++) begin
            rdat = (i >= 5 && i <= 10) ? rd_bytes[i-5] : 8'h00;
            expect_cmd($sformatf("%s_cmd%0d", tag, i), bp, 1'b0, rdat, rd_exp[i]);
        end
    endtask

    initial begin
        int sv0;

        // Reset and startup
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset_outputs",
              {cmd_valid, cmd_op, cmd_data, accel_x, accel_y, accel_z, sample_valid, error, busy},
              64'd0);
        RST = 1'b0;
        hs_bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (cmd_valid !== 1'b0) hs_bad = 1'b1;
        end
        check("startup_quiet", {63'd0, hs_bad}, 64'd0);
        @(negedge CLK);
        check("startup_first_valid", {62'd0, cmd_valid, busy}, 64'd3);
        for (int i = 0; i < 10; i++)
            expect_cmd($sformatf("cfg_cmd%0d", i), 0, 1'b0, 8'h00, cfg_exp[i]);
        check("cfg_done_idle", {63'd0, busy}, 64'd0);

        // Normal read
        rd_bytes = '{8'h34, 8'h12, 8'hFE, 8'hFF, 8'h00, 8'h01};
        sv0 = sv_cnt;
        hs_bad = 1'b0;
        run_read("rd1", 0, 12);
        check("rd1_pulse", {63'd0, sample_valid}, 64'd1);
        check("rd1_accel", {16'd0, accel_x, accel_y, accel_z}, 64'h0000_1234_FFFE_0100);
        check("rd1_err_busy", {62'd0, error, busy}, 64'd0);
        @(negedge CLK);
        check("rd1_single_pulse", 64'(sv_cnt - sv0), 64'd1);
        check("rd1_wait_idle", {63'd0, busy}, 64'd0);
        check("rd1_handshake", {63'd0, hs_bad}, 64'd0);

        // Backpressure read
        rd_bytes = '{8'h01, 8'h80, 8'hAA, 8'h55, 8'hFF, 8'h7F};
        sv0 = sv_cnt;
        hs_bad = 1'b0;
        run_read("rd2", 7, 12);
        check("rd2_pulse", {63'd0, sample_valid}, 64'd1);
        check("rd2_accel", {16'd0, accel_x, accel_y, accel_z}, 64'h0000_8001_55AA_7FFF);
        @(negedge CLK);
        check("rd2_single_pulse", 64'(sv_cnt - sv0), 64'd1);
        check("rd2_stable", {63'd0, hs_bad}, 64'd0);

        // NACK on WRITE 0x32
        sv0 = sv_cnt;
        expect_cmd("nk_start", 0, 1'b0, 8'h00, 11'h000);
        expect_cmd("nk_addr", 0, 1'b0, 8'h00, 11'h23A);
        expect_cmd("nk_reg", 0, 1'b1, 8'h00, 11'h232);
        check("nk_err_busy", {62'd0, error, busy}, 64'd3);
        expect_cmd("nk_stop", 0, 1'b0, 8'h00, 11'h500);
        check("nk_after_stop", {62'd0, error, busy}, 64'd2);
        check("nk_accel_kept", {16'd0, accel_x, accel_y, accel_z}, 64'h0000_8001_55AA_7FFF);
        check("nk_no_sample", 64'(sv_cnt - sv0), 64'd0);

        // Recovery read clears error
        rd_bytes = '{8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00};
        run_read("rd3", 0, 12);
        check("rd3_pulse_err", {62'd0, sample_valid, error}, 64'd2);
        check("rd3_accel", {16'd0, accel_x, accel_y, accel_z}, 64'h0000_0010_0020_0030);

        // enable gating in WAIT
        enable = 1'b0;
        hs_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (cmd_valid !== 1'b0 || busy !== 1'b0) hs_bad = 1'b1;
        end
        check("en_low_quiet", {63'd0, hs_bad}, 64'd0);
        enable = 1'b1;
        @(negedge CLK);
        check("en_rise_read", {62'd0, busy, cmd_valid}, 64'd2);
        @(negedge CLK);
        check("en_rise_start", {52'd0, cmd_valid, cmd_op, cmd_data}, {52'd0, 1'b1, 11'h000});

        // Reset mid-read after the third data byte
        rd_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11, 8'h22};
        run_read("rd4", 0, 8);
        RST = 1'b1;
        @(negedge CLK);
        check("midread_reset_outputs",
              {cmd_valid, cmd_op, cmd_data, accel_x, accel_y, accel_z, sample_valid, error, busy},
              64'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 3; i++)
            expect_cmd($sformatf("recfg_cmd%0d", i), 0, 1'b0, 8'h00, cfg_exp[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
